shift_cmd_ctrl: RTL and testbench

Command sequencer upstream of the 32-bit serial shift stage. Queues shift requests (data, direction, amount) from a valid/ready source in a small FIFO and drives the shifter for each one: one load cycle, then one enable cycle per bit of shift. It then captures the shifter output and presents it on a valid/ready result port. The block owns all shifter sequencing, so the shift stage stays a plain datapath.

---
 rtl/shift_cmd_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_shift_cmd_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_ctrl.sv
// shift_cmd_ctrl
//
// Command sequencer for a plain serial shift stage. Shift requests (operand,
// direction, amount) are queued in a small FIFO. For each one the block issues
// a single load cycle, then one enable cycle per bit position. It captures the
// shifter output and offers it on a result port.
//
// Ports:
//   clk, clr              clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_data/cmd_dir/cmd_amt payload
//   sh_load, sh_in        shifter load strobe and operand
//   sh_en, sh_dir         shifter one-bit step strobe and direction (1 = right)
//   sh_q                  shifter register output
//   res_valid/res_ready   result handshake; res_data payload
//   busy                  FSM is not idle
//   level                 FIFO occupancy
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Once raised, valid and its payload hold until that transfer. ready and
// valid outputs here come only from registers, never from the partner's
// valid/ready input.
module shift_cmd_ctrl #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH-1:0]           cmd_data,
    input  logic                       cmd_dir,
    input  logic [AMT_W-1:0]           cmd_amt,
    output logic                       sh_load,
    output logic [WIDTH-1:0]           sh_in,
    output logic                       sh_en,
    output logic                       sh_dir,
    input  logic [WIDTH-1:0]           sh_q,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + 1 + AMT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               sh_load_q, sh_load_d;
    logic               sh_en_q, sh_en_d;
    logic [WIDTH-1:0]   sh_in_q, sh_in_d;
    logic               sh_dir_q, sh_dir_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;

    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   head;

    assign cmd_ready = (level_q != LVL_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // Pop only looks at registered occupancy, so a command written into an
    // empty FIFO is seen one cycle after its push edge.
    assign pop       = (state_q == S_IDLE) && (level_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_dir, cmd_amt, cmd_data};
        end
    end

    // Strobes are registered from the next state, so sh_load is high exactly
    // while in LOAD and sh_en exactly while in SHIFT. sh_in_q/sh_dir_q double
    // as the working operand and direction of the command in flight.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        cnt_d       = cnt_q;
        sh_load_d   = 1'b0;
        sh_en_d     = 1'b0;
        sh_in_d     = sh_in_q;
        sh_dir_d    = sh_dir_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    sh_in_d   = head[WIDTH-1:0];
                    cnt_d     = head[WIDTH+AMT_W-1:WIDTH];
                    sh_dir_d  = head[ENT_W-1];
                    sh_load_d = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q != '0) begin
                    sh_en_d = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    sh_en_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                res_data_d  = sh_q;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            sh_load_q   <= 1'b0;
            sh_en_q     <= 1'b0;
            sh_in_q     <= '0;
            sh_dir_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            sh_load_q   <= sh_load_d;
            sh_en_q     <= sh_en_d;
            sh_in_q     <= sh_in_d;
            sh_dir_q    <= sh_dir_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign sh_load   = sh_load_q;
    assign sh_en     = sh_en_q;
    assign sh_in     = sh_in_q;
    assign sh_dir    = sh_dir_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE);
    assign level     = level_q;

endmodule

// File: tb/tb_shift_cmd_ctrl.sv
module tb_shift_cmd_ctrl;

    logic        clk;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        cmd_dir;
    logic [4:0]  cmd_amt;
    logic        sh_load;
    logic [31:0] sh_in;
    logic        sh_en;
    logic        sh_dir;
    logic [31:0] sh_q;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic [2:0]  level;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    // activity counters, sampled on the falling edge
    int cyc = 0;
    int load_cnt = 0;
    int en_cnt = 0;
    int load_cyc = 0;
    int rv_cyc = 0;
    int run = 0;
    int last_run = 0;
    bit rv_prev = 1'b0;

    shift_cmd_ctrl #(.WIDTH(32), .AMT_W(5), .DEPTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_amt   (cmd_amt),
        .sh_load   (sh_load),
        .sh_in     (sh_in),
        .sh_en     (sh_en),
        .sh_dir    (sh_dir),
        .sh_q      (sh_q),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .level     (level)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // behavioural shifter stage
    always @(posedge clk) begin
        if (sh_load)     sh_q <= sh_in;
        else if (sh_en)  sh_q <= sh_dir ? (sh_q >> 1) : (sh_q << 1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // result monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] e;
        if (clr && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", res_data, 32'hxxxxxxxx);
            end else begin
                e = exp_q.pop_front();
                chk("result", res_data, e);
            end
        end
    end

    // shifter strobe activity
    always @(negedge clk) begin
        if (sh_load && sh_en) begin
            total++;
            bad++;
            $display("FAIL load_en_overlap: sh_load=%b sh_en=%b expected not both", sh_load, sh_en);
        end
        if (sh_load) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (sh_en) begin
            en_cnt++;
            run++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (res_valid && !rv_prev) rv_cyc = cyc;
        rv_prev = res_valid;
    end

    // driver: offer one command and hold it until accepted
    task automatic push(input logic [31:0] d, input bit dir, input logic [4:0] amt,
                        input logic [31:0] exp);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_amt   = amt;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", {31'b0, cmd_ready}, 32'd1);
        end else begin
            exp_q.push_back(exp);
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({name, "_pending"}, exp_q.size(), 32'd0);
        chk({name, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run_one(input string name, input logic [31:0] d, input bit dir,
                           input logic [4:0] amt, input logic [31:0] exp);
        int l0, e0;
        l0 = load_cnt;
        e0 = en_cnt;
        push(d, dir, amt, exp);
        wait_drain(name);
        chk({name, "_loads"}, load_cnt - l0, 32'd1);
        chk({name, "_enables"}, en_cnt - e0, {27'b0, amt});
        chk({name, "_latency"}, rv_cyc - load_cyc, amt + 32'd2);
        if (amt != 0) chk({name, "_run"}, last_run, {27'b0, amt});
    endtask

    initial begin
        int e0;
        int n;
        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_amt   = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_level", {29'b0, level}, 32'd0);
        chk("rst_outputs", {26'b0, sh_load, sh_en, sh_dir, res_valid, busy, 1'b0}, 32'd0);
        chk("rst_sh_in", sh_in, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        clr = 1'b1;

        // single commands
        run_one("left27",  32'h7105c1a6, 1'b0, 5'd27, 32'h30000000);
        run_one("right27", 32'h7105c1a6, 1'b1, 5'd27, 32'h0000000e);
        run_one("amt0",    32'h7105c1a6, 1'b0, 5'd0,  32'h7105c1a6);
        run_one("left31",  32'h00000001, 1'b0, 5'd31, 32'h80000000);

        // back-pressure: consumer stalled, FIFO fills behind the held result
        @(posedge clk); #1 res_ready = 1'b0;
        push(32'h00000001, 1'b0, 5'd1, 32'h00000002);
        push(32'h80000000, 1'b1, 5'd1, 32'h40000000);
        push(32'h0000f00f, 1'b0, 5'd1, 32'h0001e01e);
        push(32'h12345678, 1'b1, 5'd1, 32'h091a2b3c);
        push(32'hffffffff, 1'b0, 5'd1, 32'hfffffffe);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 32'ha5a5a5a5;
        cmd_dir   = 1'b0;
        cmd_amt   = 5'd1;
        repeat (3) @(negedge clk);
        chk("full_ready", {31'b0, cmd_ready}, 32'd0);
        chk("full_level", {29'b0, level}, 32'd4);
        chk("full_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain("backpressure");

        // push and pop in the same cycle
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 32'h00000003;
        cmd_dir   = 1'b0;
        cmd_amt   = 5'd2;
        exp_q.push_back(32'h0000000c);
        @(posedge clk); #1;
        cmd_data  = 32'hf0000000;
        cmd_dir   = 1'b1;
        cmd_amt   = 5'd3;
        exp_q.push_back(32'h1e000000);
        @(negedge clk);
        chk("pp_level_before", {29'b0, level}, 32'd1);
        chk("pp_idle_before", {31'b0, busy}, 32'd0);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("pp_level_after", {29'b0, level}, 32'd1);
        chk("pp_busy_after", {31'b0, busy}, 32'd1);
        push(32'h0f0f0f0f, 1'b0, 5'd4, 32'hf0f0f0f0);
        push(32'h00ff00ff, 1'b1, 5'd8, 32'h0000ff00);
        wait_drain("pushpop");

        // reset mid-shift with two commands queued
        e0 = en_cnt;
        push(32'h7105c1a6, 1'b0, 5'd27, 32'h30000000);
        push(32'h11111111, 1'b0, 5'd1,  32'h22222222);
        push(32'h22222222, 1'b1, 5'd1,  32'h11111111);
        n = 0;
        while (en_cnt - e0 < 10 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("midrst_enables", en_cnt - e0, 32'd10);
        #2 clr = 1'b0;
        #1;
        chk("midrst_sh_en", {31'b0, sh_en}, 32'd0);
        chk("midrst_level", {29'b0, level}, 32'd0);
        chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        clr = 1'b1;
        run_one("after_rst", 32'h000000ff, 1'b1, 5'd4, 32'h0000000f);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
